// File: rtl/mm_output_registers.sv
// Output register stage of the matrix-multiplier datapath.
// Two independent registered channels share one clock and one synchronous reset:
//   FD: narrows the wide accumulated result to DATA_WIDTH and flags overflow.
//   PP: pipelines a 2*DATA_WIDTH partial product together with its carry bit.
// Every output comes straight from a flop, so there is no input-to-output combinational path.
module mm_output_registers #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                      clk,
    // Active-high despite the name; the name is kept so existing instantiations still match.
    input  logic                      reset_n,

    input  logic                      en_FDReg,
    input  logic [2*DATA_WIDTH:0]     fd_inData,
    output logic [DATA_WIDTH-1:0]     fd_outData,
    output logic                      resultIsInvalid,

    input  logic                      en_PPReg,
    input  logic [2*DATA_WIDTH-1:0]   pp_inData,
    input  logic                      pp_cin,
    output logic [2*DATA_WIDTH-1:0]   pp_outData,
    output logic                      pp_cout
);

    logic [DATA_WIDTH-1:0]   fd_data_d, fd_data_q;
    logic                    fd_invalid_d, fd_invalid_q;
    logic [2*DATA_WIDTH-1:0] pp_data_d, pp_data_q;
    logic                    pp_carry_d, pp_carry_q;
    logic                    fd_overflow;

    // Any set bit at or above DATA_WIDTH means the result cannot be represented after truncation.
    assign fd_overflow = |fd_inData[2*DATA_WIDTH:DATA_WIDTH];

    // FD next state: load the truncated low slice and its overflow flag, otherwise hold.
    always_comb begin
        fd_data_d    = fd_data_q;
        fd_invalid_d = fd_invalid_q;
        if (en_FDReg) begin
            fd_data_d    = fd_inData[DATA_WIDTH-1:0];
            fd_invalid_d = fd_overflow;
        end
    end

    // PP next state: load the partial product and carry together, otherwise hold.
    always_comb begin
        pp_data_d  = pp_data_q;
        pp_carry_d = pp_carry_q;
        if (en_PPReg) begin
            pp_data_d  = pp_inData;
            pp_carry_d = pp_cin;
        end
    end

    // FD register; reset wins over a load requested on the same edge.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            fd_data_q    <= '0;
            fd_invalid_q <= 1'b0;
        end else begin
            fd_data_q    <= fd_data_d;
            fd_invalid_q <= fd_invalid_d;
        end
    end

    // PP register; reset wins over a load requested on the same edge.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            pp_data_q  <= '0;
            pp_carry_q <= 1'b0;
        end else begin
            pp_data_q  <= pp_data_d;
            pp_carry_q <= pp_carry_d;
        end
    end

    // Outputs are the flops themselves.
    assign fd_outData      = fd_data_q;
    assign resultIsInvalid = fd_invalid_q;
    assign pp_outData      = pp_data_q;
    assign pp_cout         = pp_carry_q;

endmodule

// File: tb/tb_mm_output_registers.sv
// Self-checking bench for mm_output_registers: randomized stimulus against an arithmetic
// reference model, plus literal expectations at the directed points.
module tb_mm_output_registers;

    localparam int W   = 8;
    localparam int FDW = 2 * W + 1;
    localparam int PPW = 2 * W;
    localparam int LIM = 1 << W;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic           en_FDReg = 1'b0;
    logic [FDW-1:0] fd_inData = '0;
    logic [W-1:0]   fd_outData;
    logic           resultIsInvalid;
    logic           en_PPReg = 1'b0;
    logic [PPW-1:0] pp_inData = '0;
    logic           pp_cin = 1'b0;
    logic [PPW-1:0] pp_outData;
    logic           pp_cout;

    mm_output_registers #(.DATA_WIDTH(W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .en_FDReg       (en_FDReg),
        .fd_inData      (fd_inData),
        .fd_outData     (fd_outData),
        .resultIsInvalid(resultIsInvalid),
        .en_PPReg       (en_PPReg),
        .pp_inData      (pp_inData),
        .pp_cin         (pp_cin),
        .pp_outData     (pp_outData),
        .pp_cout        (pp_cout)
    );

    always #5 clk = ~clk;

    // Reference model: values the outputs must show after each rising edge.
    int exp_fd  = 0;
    int exp_inv = 0;
    int exp_pp  = 0;
    int exp_co  = 0;

    always @(posedge clk) begin
        if (reset_n) begin
            exp_fd  <= 0;
            exp_inv <= 0;
            exp_pp  <= 0;
            exp_co  <= 0;
        end else begin
            if (en_FDReg) begin
                exp_fd  <= int'(fd_inData) % LIM;
                exp_inv <= (int'(fd_inData) > LIM - 1) ? 1 : 0;
            end
            if (en_PPReg) begin
                exp_pp <= int'(pp_inData);
                exp_co <= int'(pp_cin);
            end
        end
    end

    // Literal expectations, set alongside the inputs and checked at the following falling edge.
    logic           chk_on = 1'b0;
    logic           pin_fd_on = 1'b0;
    logic [W-1:0]   pin_fd_val = '0;
    logic           pin_inv_val = 1'b0;
    logic           pin_pp_on = 1'b0;
    logic [PPW-1:0] pin_pp_val = '0;
    logic           pin_co_val = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("fd_outData", 32'(fd_outData), 32'(exp_fd));
            check("resultIsInvalid", 32'(resultIsInvalid), 32'(exp_inv));
            check("pp_outData", 32'(pp_outData), 32'(exp_pp));
            check("pp_cout", 32'(pp_cout), 32'(exp_co));
            if (pin_fd_on) begin
                check("fd_outData_literal", 32'(fd_outData), 32'(pin_fd_val));
                check("resultIsInvalid_literal", 32'(resultIsInvalid), 32'(pin_inv_val));
            end
            if (pin_pp_on) begin
                check("pp_outData_literal", 32'(pp_outData), 32'(pin_pp_val));
                check("pp_cout_literal", 32'(pp_cout), 32'(pin_co_val));
            end
        end
    end

    // Drive one cycle of inputs just after the falling edge; clears pending literal checks.
    task automatic cyc(input logic rst, input logic efd, input logic [FDW-1:0] fdi,
                       input logic epp, input logic [PPW-1:0] ppi, input logic ci);
        @(negedge clk);
        #1;
        reset_n   = rst;
        en_FDReg  = efd;
        fd_inData = fdi;
        en_PPReg  = epp;
        pp_inData = ppi;
        pp_cin    = ci;
        pin_fd_on = 1'b0;
        pin_pp_on = 1'b0;
    endtask

    task automatic pin_fd(input logic [W-1:0] d, input logic inv);
        pin_fd_on   = 1'b1;
        pin_fd_val  = d;
        pin_inv_val = inv;
    endtask

    task automatic pin_pp(input logic [PPW-1:0] d, input logic c);
        pin_pp_on  = 1'b1;
        pin_pp_val = d;
        pin_co_val = c;
    endtask

    task automatic rand_cyc(input logic rst, input logic efd, input logic epp);
        logic [31:0] r1;
        logic [31:0] r2;
        r1 = $urandom();
        r2 = $urandom();
        cyc(rst, efd, r1[FDW-1:0], epp, r2[PPW-1:0], r2[31]);
    endtask

    initial begin
        logic [31:0] r;

        // 1: reset beats both enables with non-zero inputs
        cyc(1'b1, 1'b1, 17'h1ABCD, 1'b1, 16'hA5A5, 1'b1);
        chk_on = 1'b1;
        pin_fd(8'h00, 1'b0);
        pin_pp(16'h0000, 1'b0);

        // 2: in-range FD loads
        cyc(1'b0, 1'b1, 17'h000C8, 1'b0, 16'h1111, 1'b1);
        pin_fd(8'hC8, 1'b0);
        cyc(1'b0, 1'b1, 17'h000FF, 1'b0, 16'h2222, 1'b0);
        pin_fd(8'hFF, 1'b0);

        // 3: overflowing FD loads
        cyc(1'b0, 1'b1, 17'h00100, 1'b0, 16'h3333, 1'b1);
        pin_fd(8'h00, 1'b1);
        cyc(1'b0, 1'b1, 17'h0012C, 1'b0, 16'h4444, 1'b0);
        pin_fd(8'h2C, 1'b1);
        cyc(1'b0, 1'b1, 17'h1FFFF, 1'b0, 16'h5555, 1'b1);
        pin_fd(8'hFF, 1'b1);
        // FD holds when disabled
        cyc(1'b0, 1'b0, 17'h00001, 1'b0, 16'h6666, 1'b0);
        pin_fd(8'hFF, 1'b1);

        // 4: PP hold after reset, then a single load
        cyc(1'b1, 1'b0, 17'h00000, 1'b0, 16'h0000, 1'b0);
        pin_pp(16'h0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            r = $urandom();
            cyc(1'b0, 1'b0, r[FDW-1:0], 1'b0, (i % 2 == 0) ? 16'hBEEF : r[31:16], r[i]);
            pin_pp(16'h0000, 1'b0);
        end
        cyc(1'b0, 1'b0, 17'h00000, 1'b1, 16'hBEEF, 1'b1);
        pin_pp(16'hBEEF, 1'b1);

        // 5: random enable interleave on both channels
        for (int i = 0; i < 20; i++) begin
            r = $urandom();
            rand_cyc(1'b0, r[0], r[1]);
        end

        // 6: reset in the middle of streaming, then resume
        for (int i = 0; i < 8; i++) rand_cyc(1'b0, 1'b1, 1'b1);
        rand_cyc(1'b1, 1'b1, 1'b1);
        pin_fd(8'h00, 1'b0);
        pin_pp(16'h0000, 1'b0);
        cyc(1'b0, 1'b1, 17'h000AB, 1'b1, 16'h1234, 1'b1);
        pin_fd(8'hAB, 1'b0);
        pin_pp(16'h1234, 1'b1);
        cyc(1'b0, 1'b1, 17'h10180, 1'b1, 16'hFFFF, 1'b0);
        pin_fd(8'h80, 1'b1);
        pin_pp(16'hFFFF, 1'b0);

        // Long random soak with occasional resets
        for (int i = 0; i < 300; i++) begin
            r = $urandom();
            rand_cyc(r[7:0] == 8'h00 || r[7:4] == 4'hF && r[0], r[8], r[9]);
        end

        cyc(1'b0, 1'b0, 17'h00000, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mm_output_registers.md
Name: mm_output_registers

Overview:
- Output register stage of the matrix-multiplier datapath. It holds two independent registers that share one clock and one reset.
- Final-data register (FD): captures the wide accumulated result and narrows it to DATA_WIDTH. It raises resultIsInvalid when the result does not fit.
- Partial-product register (PP): pipelines a 2*DATA_WIDTH partial product together with its carry bit, between multiplier/adder stages.
- Each channel has its own enable and is otherwise independent of the other.

Parameters:
- DATA_WIDTH, 8, width of a matrix element. The PP path is 2*DATA_WIDTH bits. The FD input is 2*DATA_WIDTH+1 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-high reset. The name is kept for codebase consistency; a value of 1 resets the block.
- en_FDReg  input  1  load enable for the FD register.
- fd_inData  input  2*DATA_WIDTH+1  accumulated result to be narrowed.
- fd_outData  output  DATA_WIDTH  registered, narrowed result.
- resultIsInvalid  output  1  registered overflow flag for fd_outData.
- en_PPReg  input  1  load enable for the PP register.
- pp_inData  input  2*DATA_WIDTH  partial product.
- pp_cin  input  1  carry accompanying pp_inData.
- pp_outData  output  2*DATA_WIDTH  registered partial product.
- pp_cout  output  1  registered carry.

Behaviour:
- All outputs are flops; there is no combinational path from input to output.
- Reset:
  - When reset_n=1 at a rising edge, fd_outData, resultIsInvalid, pp_outData and pp_cout all go to 0.
  - Reset has priority over both enables.
  - Reset asserted mid-operation clears state on that same edge. Any load requested on that edge is discarded.
- FD channel:
  - Applies when reset_n=0 and en_FDReg=1 at an edge.
  - fd_outData <= fd_inData[DATA_WIDTH-1:0], a truncated low slice. No saturation is applied.
  - resultIsInvalid <= 1 when fd_inData[2*DATA_WIDTH:DATA_WIDTH] is non-zero, i.e. fd_inData > 2^DATA_WIDTH-1. Otherwise resultIsInvalid <= 0.
  - Boundaries for DATA_WIDTH=8: 0x0FF is valid; 0x100 is invalid; 0x1FFFF is invalid with output 0xFF.
  - With en_FDReg=0, both FD outputs hold their values.
- PP channel:
  - Applies when reset_n=0 and en_PPReg=1 at an edge: pp_outData <= pp_inData and pp_cout <= pp_cin.
  - With en_PPReg=0, both PP outputs hold their values.
- Latency is one clock for both channels. New data is visible on the cycle after the load edge.
- The enables may toggle every cycle. Back-to-back loads each capture the current input; there is no handshake or backpressure.
- The two channels never interact. Simultaneous loads on both channels are legal and independent.

Test Plan:
1. Reset with reset_n=1, en_FDReg=1 and en_PPReg=1, inputs non-zero -> next cycle fd_outData=0x00, resultIsInvalid=0, pp_outData=0x0000, pp_cout=0.
2. FD in-range loads: en_FDReg=1, fd_inData=200 (0x0C8), then 255 (0x0FF) -> fd_outData=0xC8 then 0xFF, resultIsInvalid=0 both cycles, each one cycle after the load.
3. FD overflow loads: fd_inData=256 (0x100), then 300 (0x12C), then 0x1FFFF -> fd_outData=0x00, 0x2C, 0xFF respectively, resultIsInvalid=1 each time.
4. PP hold: after reset, en_PPReg=0 for 10 cycles with random pp_inData (e.g. 0xBEEF) and pp_cin=0/1 -> pp_outData stays 0x0000 and pp_cout stays 0. Then en_PPReg=1 with pp_inData=0xBEEF, pp_cin=1 -> pp_outData=0xBEEF, pp_cout=1.
5. Hold/enable interleave on both channels simultaneously for 20 random cycles -> each output equals its last-enabled input, delayed by one cycle. The two channels show no cross-effect.
6. Reset during streaming: FD and PP loading every cycle, then reset_n=1 for one cycle -> all outputs 0 on the next cycle, and loading resumes on the cycle after reset deasserts.
